tick_gen: RTL and testbench
===========================

// Module: tick_gen
// PURPOSE
//  Multi-channel programmable tick generator; successor to the fixed 4-rate divider.
//  Each channel divides CLOCK_50 by a runtime-loadable divisor and emits 1-cycle tick pulses.
//  Consumers (game loop, animation, input polling, VGA helpers) use ticks as clock enables.
//  Consumers never use ticks as derived clocks; everything stays on CLOCK_50.
// PARAMETERS
//  NUM_CH       4           number of independent channels (1..16)
//  CNT_W        32          divisor/counter width in bits
//  DEFAULT_DIV  50000000    divisor loaded into every channel at reset (1 Hz at 50 MHz)
// PORTS
//  CLOCK_50   in   1              system clock; the only clock in this block
//  reset      in   1              synchronous, active-high reset
//  ch_en      in   NUM_CH         per-channel run enable
//  wr_en      in   1              divisor write strobe
//  wr_ch      in   $clog2(NUM_CH) channel index for the write (clamped to 1 bit if NUM_CH==1)
//  wr_div     in   CNT_W          new divisor value
//  restart    in   1              resynchronise all channels (phase align)
//  tick       out  NUM_CH         1-cycle pulse per channel period, registered
//  busy_ch    out  NUM_CH         1 while a channel is enabled and counting
// BEHAVIOUR
//  - Reset: count[i]=0, div[i]=DEFAULT_DIV, tick=0, busy_ch=0 (and sq=0 if SQUARE_EN).
//  - Per channel, each posedge when ch_en[i]=1:
//      count==0 -> tick[i]<=1 next cycle; count<=eff_div-1.
//      else     -> tick[i]<=0; count<=count-1.
//  - Period = eff_div cycles; eff_div = (div==0) ? 1 : div. Divisor 0 or 1 gives a tick every cycle.
//  - First tick after reset: on the first cycle with ch_en[i]=1 (count starts at 0).
//    Tick latency is 1 cycle from that edge.
//  - ch_en[i]=0: count holds its value, tick[i]=0, busy_ch[i]=0.
//    Re-enable resumes the same count; there is no skipped or extra tick.
//  - wr_en: div[wr_ch]<=wr_div. The running count is NOT disturbed.
//    The new value takes effect at the next reload (glitch-free rate change).
//  - wr_ch >= NUM_CH: write ignored.
//  - restart=1: every channel's count<=0, tick<=0 that cycle.
//    Enabled channels tick on the following count==0 edge, so all enabled channels align.
//  - restart and wr_en in the same cycle: div is written and count<=0.
//    The next reload uses the new divisor.
//  - reset dominates restart and wr_en. Reset mid-count discards all state, including written divisors.
//  - Arithmetic: unsigned CNT_W. Decrement never wraps, because count==0 always reloads.
// CONFIGURATION
//  TICK_GEN_SQUARE_EN defined:
//    Adds output sq [NUM_CH], one register per channel, reset 0, toggling on every tick.
//    sq[i] is a 50%-duty square wave of period 2*eff_div, intended for LEDs/buzzer.
//    restart clears sq to 0.
//  Not defined: port sq and its registers are absent. All other behaviour is identical.
// STRUCTURE
//  - tick_gen_pkg holds:
//      clock constant CLK_HZ=50000000
//      rate presets DIV_50MHZ=1, DIV_25HZ=2000000, DIV_10HZ=5000000, DIV_1HZ=50000000
//      helper function hz_to_div(hz) = CLK_HZ/hz
//  - Sub-module tick_gen_channel (one counter + divisor register + tick flop), instantiated NUM_CH times via generate.
//  - Top level does write decode, restart fan-out and the optional square toggles.
// TESTING
//  1. Reset, ch_en=0001, DEFAULT_DIV overridden to 4.
//     -> tick[0] on cycles 1,5,9,...; other ticks stay 0.
//  2. div[1]=3 while ch1 is mid-count at count=2.
//     -> the current period finishes unchanged; subsequent ticks are 3 cycles apart.
//  3. wr_div=0 then wr_div=1 on ch2, enabled.
//     -> tick[2]=1 every cycle in both cases.
//  4. ch_en[0] dropped for 7 cycles at count=2, then raised.
//     -> no ticks while low; the next tick comes 3 cycles after re-enable.
//  5. Divisors 4, 6, 10, channels free-running, then restart pulse.
//     -> all three tick together 1 cycle later, then at 4/6/10-cycle spacing.
//  6. TICK_GEN_SQUARE_EN, div=3.
//     -> sq toggles every 3 cycles (period 6); reset mid-run forces sq=0, tick=0, div=DEFAULT_DIV.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// ----------------------------------------------------------------------------
// tick_gen_pkg
// Shared constants and helpers for the programmable tick generator.
//   CLK_HZ      : frequency of CLOCK_50, the only clock in this block
//   DIV_*       : ready-made divisors for the common consumer rates
//   hz_to_div   : converts a wanted tick rate into a divisor for CLOCK_50
//   ch_idx_w    : width of a channel index (never narrower than one bit)
// ----------------------------------------------------------------------------
package tick_gen_pkg;

    localparam int unsigned CLK_HZ    = 50_000_000;

    localparam int unsigned DIV_50MHZ = 1;
    localparam int unsigned DIV_25HZ  = 2_000_000;
    localparam int unsigned DIV_10HZ  = 5_000_000;
    localparam int unsigned DIV_1HZ   = 50_000_000;

    // A zero rate returns divisor 0, which the channels treat as "every cycle".
    function automatic int unsigned hz_to_div(input int unsigned hz);
        if (hz == 0) begin
            return 0;
        end
        return CLK_HZ / hz;
    endfunction

    // A single-channel build still needs a one-bit write index.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_gen_if.sv
// ----------------------------------------------------------------------------
// tick_gen_if
// Control and status bundle for tick_gen.
//   ch_en   : per-channel run enable
//   wr_en   : divisor write strobe
//   wr_ch   : channel index for the divisor write
//   wr_div  : new divisor value
//   restart : phase-align all channels
//   tick    : one-cycle pulse per channel period
//   busy_ch : channel enabled and counting
//   sq      : per-channel square wave, only when TICK_GEN_SQUARE_EN is defined
// The master modport belongs to whoever controls the generator; tick_gen
// itself uses the slave modport.
// ----------------------------------------------------------------------------
interface tick_gen_if
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] ch_en;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [CNT_W-1:0]  wr_div;
    logic              restart;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] busy_ch;
`ifdef TICK_GEN_SQUARE_EN
    logic [NUM_CH-1:0] sq;

    modport master (
        output ch_en, wr_en, wr_ch, wr_div, restart,
        input  tick, busy_ch, sq
    );

    modport slave (
        input  ch_en, wr_en, wr_ch, wr_div, restart,
        output tick, busy_ch, sq
    );
`else
    modport master (
        output ch_en, wr_en, wr_ch, wr_div, restart,
        input  tick, busy_ch
    );

    modport slave (
        input  ch_en, wr_en, wr_ch, wr_div, restart,
        output tick, busy_ch
    );
`endif

endinterface

// File: rtl/tick_gen_channel.sv
// ----------------------------------------------------------------------------
// tick_gen_channel
// One divider channel: divisor register, down-counter and registered tick.
//   clk_i      : CLOCK_50
//   reset_i    : synchronous active-high reset
//   en_i       : run enable; when low the count is frozen
//   wr_i       : load wr_div_i into the divisor register
//   wr_div_i   : new divisor value
//   restart_i  : force the count to zero so the next enabled edge ticks
//   tick_o     : one-cycle pulse, period = effective divisor
//   busy_o     : registered copy of the run enable
// ----------------------------------------------------------------------------
module tick_gen_channel #(
    parameter int          CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 50_000_000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_div_i,
    input  logic             restart_i,
    output logic             tick_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] div_q,   div_d;
    logic [CNT_W-1:0] effDiv;
    logic             tick_q,  tick_d;
    logic             busy_q,  busy_d;

    // Divisor 0 behaves like divisor 1 so the reload value never underflows.
    assign effDiv = (div_q == '0) ? CNT_W'(1) : div_q;

    // Next-state logic. A divisor write only touches div, so a running period
    // finishes at its old length and the new rate starts at the next reload.
    // Restart wins over counting but not over a same-cycle divisor write.
    always_comb begin
        count_d = count_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        busy_d  = en_i;

        if (wr_i) begin
            div_d = wr_div_i;
        end

        if (restart_i) begin
            count_d = '0;
        end else if (en_i) begin
            if (count_q == '0) begin
                tick_d  = 1'b1;
                count_d = effDiv - CNT_W'(1);
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // State registers; reset also discards any divisor written at runtime.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
            div_q   <= RESET_DIV;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
        end
    end

    assign tick_o = tick_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
// Multi-channel programmable tick generator. Every channel divides CLOCK_50
// by its own runtime-loadable divisor and emits one-cycle ticks meant to be
// used as clock enables, never as clocks.
//   CLOCK_50 : system clock
//   reset    : synchronous active-high reset
//   bus      : tick_gen_if slave modport (ch_en, wr_en, wr_ch, wr_div,
//              restart in; tick, busy_ch and optionally sq out)
// Optional feature macro: TICK_GEN_SQUARE_EN adds a toggling square-wave
// output sq per channel (period twice the tick period).
// ----------------------------------------------------------------------------
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = DIV_1HZ
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    tick_gen_if.slave   bus
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] tickVec;
    logic [NUM_CH-1:0] busyVec;

    // Write decode: an index with no matching channel simply selects nothing,
    // which is how out-of-range writes are ignored.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wrHit;

        assign wrHit = bus.wr_en && (bus.wr_ch == CH_W'(i));

        tick_gen_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_channel (
            .clk_i     (CLOCK_50),
            .reset_i   (reset),
            .en_i      (bus.ch_en[i]),
            .wr_i      (wrHit),
            .wr_div_i  (bus.wr_div),
            .restart_i (bus.restart),
            .tick_o    (tickVec[i]),
            .busy_o    (busyVec[i])
        );
    end

    assign bus.tick    = tickVec;
    assign bus.busy_ch = busyVec;

`ifdef TICK_GEN_SQUARE_EN
    logic [NUM_CH-1:0] sq_q, sq_d;

    // Each visible tick flips its square wave one cycle later, giving a 50%
    // duty cycle over two tick periods. Restart returns every wave to low.
    always_comb begin
        sq_d = sq_q ^ tickVec;
        if (bus.restart) begin
            sq_d = '0;
        end
    end

    // Square-wave registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sq_q <= '0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign bus.sq = sq_q;
`endif

endmodule

// File: tb/tb_tick_gen.sv
// ----------------------------------------------------------------------------
// tb_tick_gen
// Directed self-checking bench for tick_gen (4 channels, 32-bit counters,
// reset divisor 4). Inputs change 1 ns after a rising edge and outputs are
// sampled at the same point, so every step below is one clock cycle.
// ----------------------------------------------------------------------------
module tb_tick_gen;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int assertCount = 0;
    int failCount   = 0;

    tick_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    tick_gen #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (4)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus.slave)
    );

    // 100 MHz simulation clock; only relative cycle counts matter.
    always #5 clk = ~clk;

    // Advance one clock and move to the sampling point just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it, and reports a mismatch with tag and values.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Idle every input, hold reset for two cycles, then release it.
    task automatic applyStimulus();
        reset       = 1'b1;
        bus.ch_en   = '0;
        bus.wr_en   = 1'b0;
        bus.wr_ch   = '0;
        bus.wr_div  = '0;
        bus.restart = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Single-cycle divisor write with all channels still in their current state.
    task automatic writeDiv(input logic [1:0] ch, input logic [31:0] div);
        bus.wr_en  = 1'b1;
        bus.wr_ch  = ch;
        bus.wr_div = div;
        step();
        bus.wr_en  = 1'b0;
    endtask

    initial begin
        logic [3:0] expTick;

        // ---------------- Reset state ----------------
        applyStimulus();
        checkOutput("reset_tick", 32'(bus.tick), 32'h0);
        checkOutput("reset_busy", 32'(bus.busy_ch), 32'h0);

        // ---------------- 1: channel 0 at reset divisor 4 ----------------
        bus.ch_en = 4'b0001;
        for (int k = 1; k <= 9; k++) begin
            step();
            expTick = (k % 4 == 1) ? 4'b0001 : 4'b0000;
            checkOutput($sformatf("t1_tick_c%0d", k), 32'(bus.tick), 32'(expTick));
        end
        checkOutput("t1_busy", 32'(bus.busy_ch), 32'h1);

        // ---------------- 2: divisor change mid-count ----------------
        applyStimulus();
        bus.ch_en = 4'b0010;
        step();
        checkOutput("t2_first_tick", 32'(bus.tick), 32'h2);
        step();
        checkOutput("t2_c2", 32'(bus.tick), 32'h0);
        // Count is now 2; this write must not shorten the running period.
        writeDiv(2'd1, 32'd3);
        for (int k = 3; k <= 11; k++) begin
            if (k > 3) step();
            expTick = (k == 5 || k == 8 || k == 11) ? 4'b0010 : 4'b0000;
            checkOutput($sformatf("t2_tick_c%0d", k), 32'(bus.tick), 32'(expTick));
        end
        // Reset mid-run restores the divisor to 4.
        reset = 1'b1;
        step();
        checkOutput("t2_rst_tick", 32'(bus.tick), 32'h0);
        checkOutput("t2_rst_busy", 32'(bus.busy_ch), 32'h0);
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            expTick = (k == 1 || k == 5) ? 4'b0010 : 4'b0000;
            checkOutput($sformatf("t2_post_rst_c%0d", k), 32'(bus.tick), 32'(expTick));
        end

        // ---------------- 3: divisors 0 and 1 ----------------
        applyStimulus();
        writeDiv(2'd2, 32'd0);
        checkOutput("t3_idle", 32'(bus.tick), 32'h0);
        bus.ch_en = 4'b0100;
        for (int k = 1; k <= 4; k++) begin
            step();
            checkOutput($sformatf("t3_div0_c%0d", k), 32'(bus.tick), 32'h4);
        end
        writeDiv(2'd2, 32'd1);
        checkOutput("t3_wr1", 32'(bus.tick), 32'h4);
        for (int k = 1; k <= 3; k++) begin
            step();
            checkOutput($sformatf("t3_div1_c%0d", k), 32'(bus.tick), 32'h4);
        end

        // ---------------- 4: pause and resume ----------------
        applyStimulus();
        bus.ch_en = 4'b0001;
        step();
        checkOutput("t4_first_tick", 32'(bus.tick), 32'h1);
        step();
        bus.ch_en = 4'b0000;
        for (int k = 1; k <= 7; k++) begin
            step();
            checkOutput($sformatf("t4_paused_tick_c%0d", k), 32'(bus.tick), 32'h0);
        end
        checkOutput("t4_paused_busy", 32'(bus.busy_ch), 32'h0);
        bus.ch_en = 4'b0001;
        step();
        checkOutput("t4_resume_c1", 32'(bus.tick), 32'h0);
        checkOutput("t4_resume_busy", 32'(bus.busy_ch), 32'h1);
        step();
        checkOutput("t4_resume_c2", 32'(bus.tick), 32'h0);
        step();
        checkOutput("t4_resume_c3", 32'(bus.tick), 32'h1);

        // ---------------- 5: restart aligns 4/6/10 ----------------
        applyStimulus();
        writeDiv(2'd1, 32'd6);
        writeDiv(2'd2, 32'd10);
        bus.ch_en = 4'b0001;
        step();
        step();
        bus.ch_en = 4'b0011;
        step();
        step();
        step();
        bus.ch_en = 4'b0111;
        for (int k = 0; k < 5; k++) step();
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        checkOutput("t5_restart_tick", 32'(bus.tick), 32'h0);
        for (int k = 0; k <= 12; k++) begin
            step();
            expTick = {1'b0, (k % 10 == 0), (k % 6 == 0), (k % 4 == 0)};
            checkOutput($sformatf("t5_aligned_k%0d", k), 32'(bus.tick), 32'(expTick));
        end
        // Restart together with a divisor write: next reload uses the new value.
        bus.restart = 1'b1;
        writeDiv(2'd0, 32'd2);
        bus.restart = 1'b0;
        checkOutput("t5_rw_c0", 32'(bus.tick), 32'h0);
        step();
        checkOutput("t5_rw_c1", 32'(bus.tick), 32'h7);
        step();
        checkOutput("t5_rw_c2", 32'(bus.tick), 32'h0);
        step();
        checkOutput("t5_rw_c3", 32'(bus.tick), 32'h1);
        step();
        checkOutput("t5_rw_c4", 32'(bus.tick), 32'h0);
        step();
        checkOutput("t5_rw_c5", 32'(bus.tick), 32'h1);

`ifdef TICK_GEN_SQUARE_EN
        // ---------------- 6: square wave at divisor 3 ----------------
        begin
            logic [7:0] sqTable;
            sqTable = 8'b1000_1110;
            applyStimulus();
            writeDiv(2'd0, 32'd3);
            checkOutput("t6_sq_idle", 32'(bus.sq), 32'h0);
            bus.ch_en = 4'b0001;
            for (int k = 1; k <= 8; k++) begin
                step();
                expTick = (k % 3 == 1) ? 4'b0001 : 4'b0000;
                checkOutput($sformatf("t6_tick_c%0d", k), 32'(bus.tick), 32'(expTick));
                checkOutput($sformatf("t6_sq_c%0d", k), 32'(bus.sq), 32'(sqTable[k-1]));
            end
            reset = 1'b1;
            step();
            checkOutput("t6_rst_sq", 32'(bus.sq), 32'h0);
            checkOutput("t6_rst_tick", 32'(bus.tick), 32'h0);
            reset = 1'b0;
            for (int k = 1; k <= 5; k++) begin
                step();
                expTick = (k == 1 || k == 5) ? 4'b0001 : 4'b0000;
                checkOutput($sformatf("t6_post_rst_c%0d", k), 32'(bus.tick), 32'(expTick));
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
